// File: rtl/id_ex_operand_stage_if.sv
// ID -> EX bundle for the operand stage: decoded instruction, forwarding sources and EX-stage results.
// The stage connects through the slave modport and its driver through the master modport.
interface id_ex_operand_stage_if #(
  parameter int XLEN     = 32,
  parameter int REG_AW   = 5,
  parameter int ALUSIG_W = 4
);
  logic                       Stall_i;
  logic                       Flush_i;
  logic                       Valid_i;
  logic [REG_AW-1:0]          Rs1_i;
  logic [REG_AW-1:0]          Rs2_i;
  logic [REG_AW-1:0]          Rd_i;
  logic [XLEN-1:0]            Rs1Data_i;
  logic [XLEN-1:0]            Rs2Data_i;
  logic [XLEN-1:0]            Imm_i;
  logic                       ALUSrc_i;
  logic [ALUSIG_W-1:0]        ALUSignal_i;
  logic                       RegWrite_i;
  logic                       MemRead_i;
  logic                       MemWrite_i;
  logic                       MemtoReg_i;
  logic                       EXMEM_RegWrite_i;
  logic                       MEMWB_RegWrite_i;
  logic [REG_AW-1:0]          EXMEM_Rd_i;
  logic [REG_AW-1:0]          MEMWB_Rd_i;
  logic [XLEN-1:0]            EXMEM_Data_i;
  logic [XLEN-1:0]            MEMWB_Data_i;

  logic signed [XLEN-1:0]     Data1_o;
  logic signed [XLEN-1:0]     Data2_o;
  logic [ALUSIG_W-1:0]        ALUSignal_o;
  logic [XLEN-1:0]            StoreData_o;
  logic                       Valid_o;
  logic [REG_AW-1:0]          Rd_o;
  logic                       RegWrite_o;
  logic                       MemRead_o;
  logic                       MemWrite_o;
  logic                       MemtoReg_o;
  logic                       HazardStall_o;

  modport master (
    output Stall_i, Flush_i, Valid_i, Rs1_i, Rs2_i, Rd_i, Rs1Data_i, Rs2Data_i, Imm_i,
           ALUSrc_i, ALUSignal_i, RegWrite_i, MemRead_i, MemWrite_i, MemtoReg_i,
           EXMEM_RegWrite_i, MEMWB_RegWrite_i, EXMEM_Rd_i, MEMWB_Rd_i,
           EXMEM_Data_i, MEMWB_Data_i,
    input  Data1_o, Data2_o, ALUSignal_o, StoreData_o, Valid_o, Rd_o,
           RegWrite_o, MemRead_o, MemWrite_o, MemtoReg_o, HazardStall_o
  );

  modport slave (
    input  Stall_i, Flush_i, Valid_i, Rs1_i, Rs2_i, Rd_i, Rs1Data_i, Rs2Data_i, Imm_i,
           ALUSrc_i, ALUSignal_i, RegWrite_i, MemRead_i, MemWrite_i, MemtoReg_i,
           EXMEM_RegWrite_i, MEMWB_RegWrite_i, EXMEM_Rd_i, MEMWB_Rd_i,
           EXMEM_Data_i, MEMWB_Data_i,
    output Data1_o, Data2_o, ALUSignal_o, StoreData_o, Valid_o, Rd_o,
           RegWrite_o, MemRead_o, MemWrite_o, MemtoReg_o, HazardStall_o
  );
endinterface

// File: rtl/id_ex_operand_stage.sv
// ID/EX pipeline register with operand forwarding and load-use hazard detection.
// Feeds the ALU its two signed operands and operation select.
module id_ex_operand_stage #(
  parameter int XLEN     = 32,
  parameter int REG_AW   = 5,
  parameter int ALUSIG_W = 4
) (
  input logic                    clk_i,
  input logic                    rst_i,
  id_ex_operand_stage_if.slave   bus
);

  localparam int NSRC = 2;

  // Index 0 is rs1, index 1 is rs2.
  logic [NSRC-1:0][REG_AW-1:0] rs_id;
  logic [NSRC-1:0][XLEN-1:0]   rdata_id;
  logic [NSRC-1:0][XLEN-1:0]   capture_data;
  logic [NSRC-1:0][REG_AW-1:0] rs_reg;
  logic [NSRC-1:0][XLEN-1:0]   data_reg;
  logic [NSRC-1:0]             exmem_hit;
  logic [NSRC-1:0]             memwb_hit;
  logic [NSRC-1:0]             capture_hit;
  logic [NSRC-1:0][XLEN-1:0]   fwd_data;

  logic                valid_reg;
  logic [REG_AW-1:0]   rd_reg;
  logic                regwrite_reg;
  logic                memread_reg;
  logic                memwrite_reg;
  logic                memtoreg_reg;
  logic                alusrc_reg;
  logic [ALUSIG_W-1:0] alusig_reg;
  logic [XLEN-1:0]     imm_reg;

  logic hazard;
  logic bubble;
  logic load_en;

  assign rs_id[0]    = bus.Rs1_i;
  assign rs_id[1]    = bus.Rs2_i;
  assign rdata_id[0] = bus.Rs1Data_i;
  assign rdata_id[1] = bus.Rs2Data_i;

  // Conservative: rs2 is compared even when the ID instruction is I-type.
  assign hazard = valid_reg && memread_reg && (rd_reg != '0) && bus.Valid_i &&
                  ((rd_reg == bus.Rs1_i) || (rd_reg == bus.Rs2_i));

  assign bubble  = bus.Flush_i || hazard;
  assign load_en = !bus.Stall_i && !bubble;

  genvar gi;
  generate
    for (gi = 0; gi < NSRC; gi++) begin : g_src
      // WB writes the regfile on the same edge ID reads it, so take the value being written.
      assign capture_hit[gi] = bus.MEMWB_RegWrite_i && (bus.MEMWB_Rd_i != '0) &&
                               (bus.MEMWB_Rd_i == rs_id[gi]);
      assign capture_data[gi] = capture_hit[gi] ? bus.MEMWB_Data_i : rdata_id[gi];

      assign exmem_hit[gi] = bus.EXMEM_RegWrite_i && (bus.EXMEM_Rd_i != '0) &&
                             (bus.EXMEM_Rd_i == rs_reg[gi]);
      assign memwb_hit[gi] = bus.MEMWB_RegWrite_i && (bus.MEMWB_Rd_i != '0) &&
                             (bus.MEMWB_Rd_i == rs_reg[gi]);

      // Youngest producer wins.
      assign fwd_data[gi] = exmem_hit[gi] ? bus.EXMEM_Data_i :
                            memwb_hit[gi] ? bus.MEMWB_Data_i :
                                            data_reg[gi];
    end
  endgenerate

  // Data fields: loaded only on a real load, otherwise held (bubbles keep them).
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      rs_reg     <= '0;
      data_reg   <= '0;
      imm_reg    <= '0;
      alusrc_reg <= 1'b0;
      alusig_reg <= '0;
    end else if (load_en) begin
      for (int i = 0; i < NSRC; i++) begin
        rs_reg[i]   <= rs_id[i];
        data_reg[i] <= capture_data[i];
      end
      imm_reg    <= bus.Imm_i;
      alusrc_reg <= bus.ALUSrc_i;
      alusig_reg <= bus.ALUSignal_i;
    end
  end

  // Control fields: stall holds, flush/hazard inserts a bubble, else load.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      valid_reg    <= 1'b0;
      rd_reg       <= '0;
      regwrite_reg <= 1'b0;
      memread_reg  <= 1'b0;
      memwrite_reg <= 1'b0;
      memtoreg_reg <= 1'b0;
    end else if (!bus.Stall_i) begin
      if (bubble) begin
        valid_reg    <= 1'b0;
        rd_reg       <= '0;
        regwrite_reg <= 1'b0;
        memread_reg  <= 1'b0;
        memwrite_reg <= 1'b0;
        memtoreg_reg <= 1'b0;
      end else begin
        valid_reg    <= bus.Valid_i;
        rd_reg       <= bus.Rd_i;
        regwrite_reg <= bus.RegWrite_i;
        memread_reg  <= bus.MemRead_i;
        memwrite_reg <= bus.MemWrite_i;
        memtoreg_reg <= bus.MemtoReg_i;
      end
    end
  end

  assign bus.Data1_o       = fwd_data[0];
  assign bus.Data2_o       = alusrc_reg ? imm_reg : fwd_data[1];
  assign bus.StoreData_o   = fwd_data[1];
  assign bus.ALUSignal_o   = alusig_reg;
  assign bus.Valid_o       = valid_reg;
  assign bus.Rd_o          = rd_reg;
  assign bus.RegWrite_o    = regwrite_reg;
  assign bus.MemRead_o     = memread_reg;
  assign bus.MemWrite_o    = memwrite_reg;
  assign bus.MemtoReg_o    = memtoreg_reg;
  assign bus.HazardStall_o = hazard;

endmodule

// File: tb/tb_id_ex_operand_stage.sv
// Directed bench for id_ex_operand_stage: reset, forwarding, load-use, immediates, stall/flush, reset mid-hazard.
module tb_id_ex_operand_stage;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  id_ex_operand_stage_if #(.XLEN(32), .REG_AW(5), .ALUSIG_W(4)) bus ();

  id_ex_operand_stage #(.XLEN(32), .REG_AW(5), .ALUSIG_W(4)) dut (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (bus)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_id(input logic v, input logic [4:0] rs1, input logic [4:0] rs2,
                        input logic [4:0] rd, input logic [31:0] d1, input logic [31:0] d2,
                        input logic [31:0] imm, input logic alusrc, input logic [3:0] sig,
                        input logic rw, input logic mr, input logic mw, input logic m2r);
    bus.Valid_i     = v;
    bus.Rs1_i       = rs1;
    bus.Rs2_i       = rs2;
    bus.Rd_i        = rd;
    bus.Rs1Data_i   = d1;
    bus.Rs2Data_i   = d2;
    bus.Imm_i       = imm;
    bus.ALUSrc_i    = alusrc;
    bus.ALUSignal_i = sig;
    bus.RegWrite_i  = rw;
    bus.MemRead_i   = mr;
    bus.MemWrite_i  = mw;
    bus.MemtoReg_i  = m2r;
  endtask

  task automatic idle_id();
    set_id(1'b0, 5'd0, 5'd0, 5'd0, 32'h0, 32'h0, 32'h0, 1'b0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic set_fwd(input logic erw, input logic [4:0] erd, input logic [31:0] edat,
                         input logic mrw, input logic [4:0] mrd, input logic [31:0] mdat);
    bus.EXMEM_RegWrite_i = erw;
    bus.EXMEM_Rd_i       = erd;
    bus.EXMEM_Data_i     = edat;
    bus.MEMWB_RegWrite_i = mrw;
    bus.MEMWB_Rd_i       = mrd;
    bus.MEMWB_Data_i     = mdat;
  endtask

  initial begin
    bus.Stall_i = 1'b0;
    bus.Flush_i = 1'b0;
    idle_id();
    set_fwd(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;

    chk("reset_data1", bus.Data1_o, 32'h0);
    chk("reset_data2", bus.Data2_o, 32'h0);
    chk("reset_store", bus.StoreData_o, 32'h0);
    chk("reset_alusig", {28'h0, bus.ALUSignal_o}, 32'h0);
    chk("reset_valid", {31'h0, bus.Valid_o}, 32'h0);
    chk("reset_regwrite", {31'h0, bus.RegWrite_o}, 32'h0);
    chk("reset_hazard", {31'h0, bus.HazardStall_o}, 32'h0);

    // ADD x3,x1,x2
    set_id(1'b1, 5'd1, 5'd2, 5'd3, 32'd5, 32'd7, 32'h0, 1'b0, 4'd0, 1'b1, 1'b0, 1'b0, 1'b0);
    tick();
    idle_id();
    chk("add_data1", bus.Data1_o, 32'd5);
    chk("add_data2", bus.Data2_o, 32'd7);
    chk("add_alusig", {28'h0, bus.ALUSignal_o}, 32'h0);
    chk("add_valid", {31'h0, bus.Valid_o}, 32'h1);
    chk("add_rd", {27'h0, bus.Rd_o}, 32'd3);
    chk("add_regwrite", {31'h0, bus.RegWrite_o}, 32'h1);

    set_fwd(1'b1, 5'd1, 32'h11, 1'b1, 5'd1, 32'h22);
    #1 chk("fwd_exmem_first", bus.Data1_o, 32'h11);
    bus.EXMEM_RegWrite_i = 1'b0;
    #1 chk("fwd_memwb", bus.Data1_o, 32'h22);
    set_fwd(1'b1, 5'd0, 32'h11, 1'b1, 5'd0, 32'h22);
    #1 chk("fwd_x0_never", bus.Data1_o, 32'd5);
    set_fwd(1'b0, 5'd0, 32'h0, 1'b1, 5'd2, 32'h22);
    #1 chk("fwd_rs2_data2", bus.Data2_o, 32'h22);
    chk("fwd_rs2_store", bus.StoreData_o, 32'h22);
    set_fwd(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);

    // LW x5,4(x6) then ADD x7,x8,x5
    set_id(1'b1, 5'd6, 5'd0, 5'd5, 32'h1000, 32'h0, 32'd4, 1'b1, 4'd0, 1'b1, 1'b1, 1'b0, 1'b1);
    tick();
    set_id(1'b1, 5'd8, 5'd5, 5'd7, 32'd1, 32'h0, 32'h0, 1'b0, 4'd0, 1'b1, 1'b0, 1'b0, 1'b0);
    #1;
    chk("lu_hazard", {31'h0, bus.HazardStall_o}, 32'h1);
    chk("lu_lw_memread", {31'h0, bus.MemRead_o}, 32'h1);
    chk("lu_lw_data2_imm", bus.Data2_o, 32'd4);
    tick();
    chk("lu_bubble_valid", {31'h0, bus.Valid_o}, 32'h0);
    chk("lu_bubble_regwrite", {31'h0, bus.RegWrite_o}, 32'h0);
    chk("lu_bubble_memread", {31'h0, bus.MemRead_o}, 32'h0);
    chk("lu_bubble_rd", {27'h0, bus.Rd_o}, 32'h0);
    chk("lu_hazard_drop", {31'h0, bus.HazardStall_o}, 32'h0);
    tick();
    idle_id();
    set_fwd(1'b0, 5'd0, 32'h0, 1'b1, 5'd5, 32'hDEAD);
    #1;
    chk("lu_dep_valid", {31'h0, bus.Valid_o}, 32'h1);
    chk("lu_dep_rd", {27'h0, bus.Rd_o}, 32'd7);
    chk("lu_dep_data1", bus.Data1_o, 32'd1);
    chk("lu_dep_data2_fwd", bus.Data2_o, 32'hDEAD);
    set_fwd(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);

    // Capture bypass: regfile read of x9 is stale while WB writes it
    set_id(1'b1, 5'd9, 5'd0, 5'd1, 32'h0, 32'h0, 32'h0, 1'b0, 4'd0, 1'b1, 1'b0, 1'b0, 1'b0);
    set_fwd(1'b0, 5'd0, 32'h0, 1'b1, 5'd9, 32'hBEEF);
    tick();
    idle_id();
    set_fwd(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);
    #1 chk("capture_bypass", bus.Data1_o, 32'hBEEF);

    // ADDI x4,x4,-1
    set_id(1'b1, 5'd4, 5'd31, 5'd4, 32'd3, 32'h55, 32'hFFFF_FFFF, 1'b1, 4'd0, 1'b1, 1'b0, 1'b0, 1'b0);
    tick();
    set_fwd(1'b1, 5'd4, 32'h10, 1'b0, 5'd0, 32'h0);
    // SW x4,8(x3)
    set_id(1'b1, 5'd3, 5'd4, 5'd0, 32'h100, 32'h0, 32'd8, 1'b1, 4'd0, 1'b0, 1'b0, 1'b1, 1'b0);
    #1;
    chk("addi_data1", bus.Data1_o, 32'h10);
    chk("addi_data2", bus.Data2_o, 32'hFFFF_FFFF);
    tick();
    idle_id();
    chk("sw_data1", bus.Data1_o, 32'h100);
    chk("sw_data2", bus.Data2_o, 32'd8);
    chk("sw_store_fwd", bus.StoreData_o, 32'h10);
    chk("sw_memwrite", {31'h0, bus.MemWrite_o}, 32'h1);
    set_fwd(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);

    // SRL x10,x11,x12 then stall 3 cycles with flush arriving mid-stall
    set_id(1'b1, 5'd11, 5'd12, 5'd10, 32'hF0, 32'd2, 32'h0, 1'b0, 4'd9, 1'b1, 1'b0, 1'b0, 1'b0);
    tick();
    chk("srl_alusig", {28'h0, bus.ALUSignal_o}, 32'd9);
    chk("srl_data1", bus.Data1_o, 32'hF0);
    set_id(1'b1, 5'd14, 5'd15, 5'd13, 32'hAAAA, 32'd1, 32'h0, 1'b0, 4'd1, 1'b1, 1'b0, 1'b0, 1'b0);
    bus.Stall_i = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      if (i == 0) bus.Flush_i = 1'b1;
      chk($sformatf("stall%0d_data1", i), bus.Data1_o, 32'hF0);
      chk($sformatf("stall%0d_alusig", i), {28'h0, bus.ALUSignal_o}, 32'd9);
      chk($sformatf("stall%0d_rd", i), {27'h0, bus.Rd_o}, 32'd10);
      chk($sformatf("stall%0d_valid", i), {31'h0, bus.Valid_o}, 32'h1);
    end
    bus.Stall_i = 1'b0;
    tick();
    chk("flush_valid", {31'h0, bus.Valid_o}, 32'h0);
    chk("flush_rd", {27'h0, bus.Rd_o}, 32'h0);
    chk("flush_regwrite", {31'h0, bus.RegWrite_o}, 32'h0);
    chk("flush_data_kept", bus.Data1_o, 32'hF0);
    bus.Flush_i = 1'b0;
    tick();
    idle_id();
    chk("post_flush_data1", bus.Data1_o, 32'hAAAA);
    chk("post_flush_rd", {27'h0, bus.Rd_o}, 32'd13);
    chk("post_flush_alusig", {28'h0, bus.ALUSignal_o}, 32'd1);

    // Reset while a load-use hazard is pending
    set_id(1'b1, 5'd6, 5'd0, 5'd5, 32'h2000, 32'h0, 32'd12, 1'b1, 4'd0, 1'b1, 1'b1, 1'b0, 1'b1);
    tick();
    set_id(1'b1, 5'd5, 5'd0, 5'd6, 32'h0, 32'h0, 32'h0, 1'b0, 4'd0, 1'b1, 1'b0, 1'b0, 1'b0);
    #1 chk("rst_pre_hazard", {31'h0, bus.HazardStall_o}, 32'h1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    idle_id();
    chk("rst_valid", {31'h0, bus.Valid_o}, 32'h0);
    chk("rst_data1", bus.Data1_o, 32'h0);
    chk("rst_data2", bus.Data2_o, 32'h0);
    chk("rst_store", bus.StoreData_o, 32'h0);
    chk("rst_memread", {31'h0, bus.MemRead_o}, 32'h0);
    chk("rst_memtoreg", {31'h0, bus.MemtoReg_o}, 32'h0);
    chk("rst_rd", {27'h0, bus.Rd_o}, 32'h0);
    chk("rst_hazard", {31'h0, bus.HazardStall_o}, 32'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
